// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: segment glyphs, frame layout, FSM states.
package seg7_pkg;

  // Segment glyphs, bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int unsigned SEG_MSB = 15;
  localparam int unsigned SEG_LSB = 8;
  localparam int unsigned DIG_MSB = 7;
  localparam int unsigned DIG_LSB = 0;

  typedef enum logic [1:0] {
    StWait  = 2'd0,
    StBuild = 2'd1,
    StFire  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational digit decoder: 4-bit code plus decimal point to an active-high segment byte.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       dp_i,
  input  logic       hex_en_i,
  output logic [7:0] seg_o
);

  logic [6:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    unique case (code_i)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = hex_en_i ? SEG_A : SEG_BLANK;
      4'hB: glyph = hex_en_i ? SEG_B : SEG_BLANK;
      4'hC: glyph = hex_en_i ? SEG_C : SEG_BLANK;
      4'hD: glyph = hex_en_i ? SEG_D : SEG_BLANK;
      4'hE: glyph = hex_en_i ? SEG_E : SEG_BLANK;
      4'hF: glyph = hex_en_i ? SEG_F : SEG_BLANK;
      default: glyph = SEG_BLANK;
    endcase
  end

  assign seg_o = {dp_i, glyph};

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed 7-segment refresh controller: builds one segment/digit-select frame per slot
// and pulses trigger_o so the downstream 74HC595 shifter serialises it.
module seg7_scan_controller
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned FRAME_BITS     = 16,
  parameter int unsigned REFRESH_DIV    = 4096,
  parameter bit          HEX_EN         = 1'b0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_DIGITS*4-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_i,
  output logic [FRAME_BITS-1:0]   data_o,
  output logic                    trigger_o,
  output logic [2:0]              digit_idx_o
);

  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [2:0]  LAST_IDX = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]  DIG_OFF  = DIG_ACTIVE_LOW ? 8'hFF : 8'h00;

  if (FRAME_BITS != 16) begin : g_bad_frame
    $error("seg7_scan_controller: FRAME_BITS must be 16");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_controller: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 2 * FRAME_BITS + 4) begin : g_bad_div
    $error("seg7_scan_controller: REFRESH_DIV too small for the shifter");
  end

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic                    tick;
  state_e                  state_q, state_d;
  logic                    build_en, fire;
  logic [2:0]              idx_q, idx_d;
  logic [NUM_DIGITS*4-1:0] digits_q, digits_sel;
  logic [NUM_DIGITS-1:0]   dp_q, dp_sel;
  logic                    snap_load;
  logic [3:0]              cur_code;
  logic                    cur_dp;
  logic [7:0]              seg_raw, seg_byte, dig_byte;
  logic [FRAME_BITS-1:0]   frame_q, frame_d, frame_rst;

  // Prescaler
  assign tick    = (presc_q == PRESC_W'(REFRESH_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:  if (tick) state_d = StBuild;
      StBuild: state_d = StFire;
      StFire:  state_d = StWait;
      default: state_d = StWait;
    endcase
  end

  // FSM: outputs; trigger is masked by reset so a reset cycle never fires.
  always_comb begin
    build_en  = (state_q == StBuild);
    fire      = (state_q == StFire);
    trigger_o = fire & ~rst_i;
  end

  // Digit index
  always_comb begin
    idx_d = idx_q;
    if (fire) begin
      idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= 3'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign digit_idx_o = idx_q;

  // Snapshot once per scan; the idx-0 decode reads the live inputs captured this same cycle.
  assign snap_load  = build_en && (idx_q == 3'd0);
  assign digits_sel = snap_load ? digits_i : digits_q;
  assign dp_sel     = snap_load ? dp_i : dp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digits_q <= '0;
      dp_q     <= '0;
    end else if (snap_load) begin
      digits_q <= digits_i;
      dp_q     <= dp_i;
    end
  end

  always_comb begin
    cur_code = 4'h0;
    cur_dp   = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        cur_code = digits_sel[4*k +: 4];
        cur_dp   = dp_sel[k];
      end
    end
  end

  bcd_to_seg7 u_decode (
    .code_i   (cur_code),
    .dp_i     (cur_dp),
    .hex_en_i (HEX_EN),
    .seg_o    (seg_raw)
  );

  // Frame assembly; polarity applied after decode and blanking.
  always_comb begin
    seg_byte = blank_i ? 8'h00 : seg_raw;
    dig_byte = blank_i ? 8'h00 : (8'h01 << idx_q);
    frame_d  = '0;
    frame_d[SEG_MSB:SEG_LSB] = seg_byte ^ {8{SEG_ACTIVE_LOW}};
    frame_d[DIG_MSB:DIG_LSB] = dig_byte ^ {8{DIG_ACTIVE_LOW}};
    frame_rst = '0;
    frame_rst[SEG_MSB:SEG_LSB] = SEG_OFF;
    frame_rst[DIG_MSB:DIG_LSB] = DIG_OFF;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q <= frame_rst;
    end else if (build_en) begin
      frame_q <= frame_d;
    end
  end

  assign data_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller: three instances (default, hex, inverted polarity)
// share one stimulus and are checked against hand-computed frames and trigger timing.
module tb_seg7_scan_controller;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blank;

  logic [15:0] data_a, data_h, data_v;
  logic        trig_a, trig_h, trig_v;
  logic [2:0]  idx_a, idx_h, idx_v;

  int total = 0;
  int bad   = 0;

  seg7_scan_controller #(
    .NUM_DIGITS(4), .FRAME_BITS(16), .REFRESH_DIV(40),
    .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .digits_i(digits), .dp_i(dp), .blank_i(blank),
    .data_o(data_a), .trigger_o(trig_a), .digit_idx_o(idx_a)
  );

  seg7_scan_controller #(
    .NUM_DIGITS(4), .FRAME_BITS(16), .REFRESH_DIV(40),
    .HEX_EN(1'b1), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut_hex (
    .clk_i(clk), .rst_i(rst), .digits_i(digits), .dp_i(dp), .blank_i(blank),
    .data_o(data_h), .trigger_o(trig_h), .digit_idx_o(idx_h)
  );

  seg7_scan_controller #(
    .NUM_DIGITS(4), .FRAME_BITS(16), .REFRESH_DIV(40),
    .HEX_EN(1'b0), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk_i(clk), .rst_i(rst), .digits_i(digits), .dp_i(dp), .blank_i(blank),
    .data_o(data_v), .trigger_o(trig_v), .digit_idx_o(idx_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts negedges until the default instance fires; n = -1 on timeout.
  task automatic wait_trig(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!trig_a && n < 200);
    if (!trig_a) n = -1;
  endtask

  task automatic test_reset();
    int n;
    digits = 16'h1234;
    dp     = 4'h0;
    blank  = 1'b0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (data_a !== 16'h0000) begin
      bad++; $display("FAIL reset_data got=%h want=%h", data_a, 16'h0000);
    end
    total++;
    if (data_v !== 16'hFFFF) begin
      bad++; $display("FAIL reset_data_inv got=%h want=%h", data_v, 16'hFFFF);
    end
    total++;
    if (trig_a !== 1'b0 || idx_a !== 3'd0) begin
      bad++; $display("FAIL reset_trig_idx got=%b/%0d want=0/0", trig_a, idx_a);
    end
    rst = 1'b0;
    wait_trig(n);
    total++;
    if (n != 41) begin
      bad++; $display("FAIL first_trigger_cycle got=%0d want=41", n);
    end
    total++;
    if (data_a !== 16'h6601 || idx_a !== 3'd0) begin
      bad++; $display("FAIL first_frame got=%h/%0d want=6601/0", data_a, idx_a);
    end
    total++;
    if (trig_h !== 1'b1 || trig_v !== 1'b1) begin
      bad++; $display("FAIL trigger_align got=%b%b want=11", trig_h, trig_v);
    end
    @(negedge clk);
    total++;
    if (trig_a !== 1'b0 || data_a !== 16'h6601) begin
      bad++; $display("FAIL trigger_width got=%b/%h want=0/6601", trig_a, data_a);
    end
    wait_trig(n);
    total++;
    if (n != 39 || data_a !== 16'h4F02 || idx_a !== 3'd1) begin
      bad++; $display("FAIL second_trigger got=%0d/%h/%0d want=39/4f02/1", n, data_a, idx_a);
    end
  endtask

  task automatic test_full_scan();
    int n;
    logic [15:0] exp_d [0:3];
    logic [2:0]  exp_i [0:3];
    exp_d[0] = 16'h5B04; exp_i[0] = 3'd2;
    exp_d[1] = 16'h0608; exp_i[1] = 3'd3;
    exp_d[2] = 16'h6601; exp_i[2] = 3'd0;
    exp_d[3] = 16'h4F02; exp_i[3] = 3'd1;
    for (int i = 0; i < 4; i++) begin
      wait_trig(n);
      total++;
      if (n != 40 || data_a !== exp_d[i] || idx_a !== exp_i[i]) begin
        bad++;
        $display("FAIL full_scan[%0d] got=%0d/%h/%0d want=40/%h/%0d",
                 i, n, data_a, idx_a, exp_d[i], exp_i[i]);
      end
    end
  endtask

  task automatic test_snapshot();
    int n;
    logic [15:0] exp_d [0:3];
    exp_d[0] = 16'h5B04;
    exp_d[1] = 16'h0608;
    exp_d[2] = 16'h6F01;
    exp_d[3] = 16'h6F02;
    digits = 16'h9999;
    for (int i = 0; i < 4; i++) begin
      wait_trig(n);
      total++;
      if (n != 40 || data_a !== exp_d[i]) begin
        bad++; $display("FAIL snapshot[%0d] got=%0d/%h want=40/%h", i, n, data_a, exp_d[i]);
      end
    end
  endtask

  task automatic test_hex_dp();
    int n;
    digits = 16'h000A;
    dp     = 4'h0;
    repeat (2) wait_trig(n);
    total++;
    if (data_a !== 16'h6F08) begin
      bad++; $display("FAIL hex_old_scan got=%h want=6f08", data_a);
    end
    wait_trig(n);
    total++;
    if (data_a !== 16'h0001) begin
      bad++; $display("FAIL hex_off got=%h want=0001", data_a);
    end
    total++;
    if (data_h !== 16'h7701) begin
      bad++; $display("FAIL hex_on got=%h want=7701", data_h);
    end
    total++;
    if (data_v !== 16'hFFFE) begin
      bad++; $display("FAIL hex_inv got=%h want=fffe", data_v);
    end
    // dp only takes effect from the next scan's snapshot
    dp = 4'h1;
    wait_trig(n);
    total++;
    if (data_a !== 16'h3F02 || data_v !== 16'hC0FD) begin
      bad++; $display("FAIL dp_mid_scan got=%h/%h want=3f02/c0fd", data_a, data_v);
    end
    repeat (3) wait_trig(n);
    total++;
    if (data_a !== 16'h8001 || data_h !== 16'hF701 || data_v !== 16'h7FFE) begin
      bad++;
      $display("FAIL dp_on got=%h/%h/%h want=8001/f701/7ffe", data_a, data_h, data_v);
    end
  endtask

  task automatic test_blank();
    int n;
    logic [2:0] exp_i [0:3];
    exp_i[0] = 3'd1; exp_i[1] = 3'd2; exp_i[2] = 3'd3; exp_i[3] = 3'd0;
    blank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_trig(n);
      total++;
      if (n != 40 || data_a !== 16'h0000 || data_h !== 16'h0000 || idx_a !== exp_i[i]) begin
        bad++;
        $display("FAIL blank[%0d] got=%0d/%h/%h/%0d want=40/0000/0000/%0d",
                 i, n, data_a, data_h, idx_a, exp_i[i]);
      end
      total++;
      if (data_v !== 16'hFFFF) begin
        bad++; $display("FAIL blank_inv[%0d] got=%h want=ffff", i, data_v);
      end
    end
    blank = 1'b0;
    wait_trig(n);
    total++;
    if (data_a !== 16'h3F02) begin
      bad++; $display("FAIL unblank got=%h want=3f02", data_a);
    end
  endtask

  task automatic test_reset_mid_slot();
    int n;
    // Prescaler is 1 at a trigger negedge, idx becomes 2 at the next edge.
    repeat (19) @(negedge clk);
    rst = 1'b1;
    total++;
    if (trig_a !== 1'b0) begin
      bad++; $display("FAIL mid_rst_pre_trig got=%b want=0", trig_a);
    end
    @(negedge clk);
    total++;
    if (trig_a !== 1'b0 || idx_a !== 3'd0 || data_a !== 16'h0000 || data_v !== 16'hFFFF) begin
      bad++;
      $display("FAIL mid_rst_state got=%b/%0d/%h/%h want=0/0/0000/ffff",
               trig_a, idx_a, data_a, data_v);
    end
    rst = 1'b0;
    wait_trig(n);
    total++;
    if (n != 41 || data_a !== 16'h8001 || idx_a !== 3'd0) begin
      bad++; $display("FAIL mid_rst_restart got=%0d/%h/%0d want=41/8001/0", n, data_a, idx_a);
    end
  endtask

  initial begin
    rst    = 1'b1;
    digits = '0;
    dp     = '0;
    blank  = 1'b0;
    test_reset();
    test_full_scan();
    test_snapshot();
    test_hex_dp();
    test_blank();
    test_reset_mid_slot();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
